// File: rtl/itcm_loader.sv
// Streams a length-prefixed byte image into the ITCM write port and holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CKSUM_EN.
module itcm_loader #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  output logic [AW-1:0] itcm_WADDR,
  output logic [DW-1:0] itcm_WDATA,
  output logic          itcm_WEN,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [32:0] CAP = 33'(1) << AW;

  state_t        state;
  logic [1:0]    bcnt;
  logic [31:0]   shreg;
  logic [AW:0]   nwords;
  logic [AW-1:0] widx;
  logic [31:0]   idle;
  logic          accept;
  logic [31:0]   word_nx;
  logic          timeout_hit;
  logic          last_word;
`ifdef LOADER_CKSUM_EN
  logic [7:0]    xsum;
`endif

  assign accept      = s_valid && s_ready;
  assign word_nx     = {s_data, shreg[31:8]};
  assign timeout_hit = (TIMEOUT != 0) && busy && !accept && (idle == 32'(TIMEOUT - 1));
  assign last_word   = (({1'b0, widx} + 1'b1) == nwords);

  // Byte assembly shared by length and payload; bcnt reset discards any partial word.
  always_ff @(posedge clk) begin
    if (accept) shreg <= word_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      s_ready    <= 1'b0;
      itcm_WEN   <= 1'b0;
      itcm_WADDR <= '0;
      itcm_WDATA <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      bcnt       <= '0;
      widx       <= '0;
      nwords     <= '0;
      idle       <= '0;
`ifdef LOADER_CKSUM_EN
      xsum       <= '0;
`endif
    end else begin
      itcm_WEN <= 1'b0;
      if (busy) idle <= accept ? 32'd0 : idle + 32'd1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            bcnt       <= '0;
            widx       <= '0;
            idle       <= '0;
`ifdef LOADER_CKSUM_EN
            xsum       <= '0;
`endif
          end
        end
        S_LEN: begin
          if (timeout_hit) begin
            state <= S_ERR; s_ready <= 1'b0; busy <= 1'b0; err <= 1'b1;
          end else if (accept) begin
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              nwords <= word_nx[AW:0];
              if ({1'b0, word_nx} > CAP) begin
                state <= S_ERR; s_ready <= 1'b0; busy <= 1'b0; err <= 1'b1;
              end else if (word_nx == 32'd0) begin
`ifdef LOADER_CKSUM_EN
                state <= S_CKSUM;
`else
                state <= S_DONE; s_ready <= 1'b0; busy <= 1'b0;
                done  <= 1'b1;   core_rst_n <= 1'b1;
`endif
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (timeout_hit) begin
            state <= S_ERR; s_ready <= 1'b0; busy <= 1'b0; err <= 1'b1;
          end else if (accept) begin
            bcnt <= bcnt + 2'd1;
`ifdef LOADER_CKSUM_EN
            xsum <= xsum ^ s_data;
`endif
            // Word complete: write lands the cycle after its fourth byte.
            if (bcnt == 2'd3) begin
              itcm_WEN   <= 1'b1;
              itcm_WDATA <= word_nx;
              itcm_WADDR <= widx;
              widx       <= widx + 1'b1;
              if (last_word) begin
`ifdef LOADER_CKSUM_EN
                state <= S_CKSUM;
`else
                state <= S_DONE; s_ready <= 1'b0; busy <= 1'b0;
                done  <= 1'b1;   core_rst_n <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef LOADER_CKSUM_EN
        S_CKSUM: begin
          if (timeout_hit) begin
            state <= S_ERR; s_ready <= 1'b0; busy <= 1'b0; err <= 1'b1;
          end else if (accept) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == xsum) begin
              state <= S_DONE; done <= 1'b1; core_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;  err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= S_IDLE; s_ready <= 1'b0; busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itcm_loader.sv
// Directed bench for itcm_loader: table of load frames plus timeout, mid-load reset and checksum sequences.
module tb_itcm_loader;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk, rst, start, s_valid, s_ready;
  logic [7:0]    s_data;
  logic [AW-1:0] itcm_WADDR;
  logic [31:0]   itcm_WDATA;
  logic          itcm_WEN, core_rst_n, busy, done, err;

  itcm_loader #(.AW(AW), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .itcm_WADDR(itcm_WADDR), .itcm_WDATA(itcm_WDATA),
    .itcm_WEN(itcm_WEN), .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = -100;
  logic [AW-1:0] wen_addr[$];
  logic [31:0]   wen_data[$];

  // Log every write and require it one cycle after the accepted byte that completed it.
  always @(negedge clk) begin
    cyc++;
    if (itcm_WEN) begin
      wen_addr.push_back(itcm_WADDR);
      wen_data.push_back(itcm_WDATA);
      checks++;
      if (cyc - last_hs != 1) begin
        errors++;
        $display("FAIL wen_latency: got %0d cycles, want 1", cyc - last_hs);
      end
    end
    if (s_valid && s_ready) last_hs = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic hs;
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); hs = s_ready;
      tick();
      if (hs) ok = 1'b1;
    end
    s_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL load_end: no done/err within 300 cycles");
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] xor_word(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  typedef struct {
    logic [31:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_err;
  } vec_t;

  // Word i of a frame: w0, w1, then w1 + i.
  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return v.w1 + 32'(i);
  endfunction

  vec_t vecs[7];
  logic [7:0] xr;

  initial begin
    vecs[0] = '{32'd2,           32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'd0,           32'h0,         32'h0,         1'b0};
    vecs[2] = '{32'd17,          32'h0,         32'h0,         1'b1};
    vecs[3] = '{32'd1,           32'hA5A5_0F0F, 32'h0,         1'b0};
    vecs[4] = '{32'd16,          32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[5] = '{32'h0001_0000,   32'h0,         32'h0,         1'b1};
    vecs[6] = '{32'd3,           32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_s_ready",    32'(s_ready),    32'd0);
    chk("rst_wen",        32'(itcm_WEN),   32'd0);
    chk("rst_waddr",      32'(itcm_WADDR), 32'd0);
    chk("rst_wdata",      itcm_WDATA,      32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
    tick(); rst = 1'b0; tick();

    for (int v = 0; v < 7; v++) begin
      wen_addr.delete(); wen_data.delete();
      pulse_start();
      @(negedge clk);
      chk("start_busy",       32'(busy),       32'd1);
      chk("start_done",       32'(done),       32'd0);
      chk("start_s_ready",    32'(s_ready),    32'd1);
      chk("start_core_rst_n", 32'(core_rst_n), 32'd0);
      tick();
      send_byte(vecs[v].len[7:0]);
      pulse_start();   // must be ignored while busy
      send_byte(vecs[v].len[15:8]);
      send_byte(vecs[v].len[23:16]);
      send_byte(vecs[v].len[31:24]);
      xr = 8'h00;
      if (!vecs[v].exp_err) begin
        for (int i = 0; i < int'(vecs[v].len); i++) begin
          send_word(word_of(vecs[v], i));
          xr ^= xor_word(word_of(vecs[v], i));
        end
`ifdef LOADER_CKSUM_EN
        send_byte(xr);
`endif
      end
      wait_end();
      chk("vec_done",       32'(done),       32'(!vecs[v].exp_err));
      chk("vec_err",        32'(err),        32'(vecs[v].exp_err));
      chk("vec_core_rst_n", 32'(core_rst_n), 32'(!vecs[v].exp_err));
      chk("vec_busy",       32'(busy),       32'd0);
      chk("vec_s_ready",    32'(s_ready),    32'd0);
      chk("vec_wen_count",  32'(wen_addr.size()), vecs[v].exp_err ? 32'd0 : vecs[v].len);
      for (int i = 0; i < wen_addr.size() && i < int'(vecs[v].len); i++) begin
        chk("vec_waddr", 32'(wen_addr[i]), 32'(i));
        chk("vec_wdata", wen_data[i], word_of(vecs[v], i));
      end
      tick();
    end

    // Stall mid-word: err after TIMEOUT idle cycles, only the first word written.
    wen_addr.delete(); wen_data.delete();
    pulse_start();
    send_word(32'd2);
    send_word(32'h1234_5678);
    send_byte(8'hEF);
    send_byte(8'hBE);
    repeat (14) tick();
    @(negedge clk);
    chk("to_early_err", 32'(err), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("to_err",        32'(err),        32'd1);
    chk("to_done",       32'(done),       32'd0);
    chk("to_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("to_busy",       32'(busy),       32'd0);
    chk("to_wen_count",  32'(wen_addr.size()), 32'd1);
    tick();

    // Reset after the 3rd byte of word 1, then a fresh load starts at address 0.
    wen_addr.delete(); wen_data.delete();
    pulse_start();
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy",    32'(busy),    32'd0);
    chk("mrst_s_ready", 32'(s_ready), 32'd0);
    chk("mrst_waddr",   32'(itcm_WADDR), 32'd0);
    chk("mrst_wdata",   itcm_WDATA,   32'd0);
    repeat (5) tick();
    chk("mrst_wen_count", 32'(wen_addr.size()), 32'd1);
    wen_addr.delete(); wen_data.delete();
    pulse_start();
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
`ifdef LOADER_CKSUM_EN
    send_byte(xor_word(32'hCAFE_F00D));
`endif
    wait_end();
    chk("reload_done",      32'(done),       32'd1);
    chk("reload_wen_count", 32'(wen_addr.size()), 32'd1);
    if (wen_addr.size() > 0) begin
      chk("reload_waddr", 32'(wen_addr[0]), 32'd0);
      chk("reload_wdata", wen_data[0],      32'hCAFE_F00D);
    end
    tick();

`ifdef LOADER_CKSUM_EN
    // XOR of bytes 78 56 34 12 EF BE AD DE is 8'h2A.
    for (int k = 0; k < 2; k++) begin
      wen_addr.delete(); wen_data.delete();
      pulse_start();
      send_word(32'd2);
      send_word(32'h1234_5678);
      send_word(32'hDEAD_BEEF);
      send_byte(k == 0 ? 8'h2A : 8'h8B);
      wait_end();
      chk("ck_done",       32'(done),       32'(k == 0));
      chk("ck_err",        32'(err),        32'(k != 0));
      chk("ck_core_rst_n", 32'(core_rst_n), 32'(k == 0));
      chk("ck_wen_count",  32'(wen_addr.size()), 32'd2);
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
